board_status_led: RTL

Status indicator stage that consumes the two board-level status signals the block design exports, `init_calib_complete_0` and `gpio_io_o_0`, and drives the 8-bit `led` bank. It sits at the top level between `design_1` and the `led` pins, and replaces the direct combinational assignments to those pins. It adds input synchronisation, a heartbeat, a DDR3 calibration watchdog with sticky loss detection, and GPIO activity and edge-count display. Every `led` bit is registered.

---
 rtl/board_status_led.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/board_status_led.sv
// board_status_led
//   Registered status LED driver for the board top level. Synchronises the
//   DDR3 calibration flag and the AXI GPIO output into clk50m and drives the
//   LED bank. It provides a heartbeat, a calibration watchdog with sticky loss
//   detection, a GPIO rising-edge counter and a stretched GPIO activity pulse.
//
// Ports
//   clk50m                 in   1  50 MHz system clock
//   reset_rtl_0            in   1  asynchronous active-low reset
//   init_calib_complete_0  in   1  DDR3 calibration done (async to clk50m)
//   gpio_io_o_0            in   1  AXI GPIO output (async to clk50m)
//   led                    out  8  status LEDs, active-high, all registered
//     [0] calib status  [1] gpio level  [2] gpio activity
//     [5:3] gpio rising-edge count  [6] calib fault  [7] heartbeat
module board_status_led #(
    parameter int unsigned HB_HALF       = 25_000_000,
    parameter int unsigned FAST_HALF     = 3_125_000,
    parameter int unsigned CALIB_TIMEOUT = 100_000_000,
    parameter int unsigned STRETCH       = 2_500_000
) (
    input  logic       clk50m,
    input  logic       reset_rtl_0,
    input  logic       init_calib_complete_0,
    input  logic       gpio_io_o_0,
    output logic [7:0] led
);

    localparam int unsigned HB_W    = $clog2(HB_HALF);
    localparam int unsigned FAST_W  = $clog2(FAST_HALF);
    localparam int unsigned TIMER_W = $clog2(CALIB_TIMEOUT);
    // One extra value so STRETCH itself is representable when it is a power of two.
    localparam int unsigned ACT_W   = $clog2(STRETCH + 1);

    localparam logic [HB_W-1:0]    HB_LAST    = HB_W'(HB_HALF - 1);
    localparam logic [FAST_W-1:0]  FAST_LAST  = FAST_W'(FAST_HALF - 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CALIB_TIMEOUT - 1);
    localparam logic [ACT_W-1:0]   ACT_LOAD   = ACT_W'(STRETCH);

    typedef enum logic [1:0] {
        WAIT_CALIB,
        RUN,
        TIMEOUT,
        LOST
    } state_t;

    state_t state, state_next;

    logic               calib_m, calib_s;
    logic               gpio_m, gpio_s, gpio_d;
    logic [HB_W-1:0]    hb_cnt;
    logic               hb;
    logic [FAST_W-1:0]  fast_cnt;
    logic               fast;
    logic [TIMER_W-1:0] timer;
    logic [2:0]         edge_cnt;
    logic [ACT_W-1:0]   act;
    logic               gpio_rise;
    logic               gpio_any;
    logic [7:0]         led_next;

    assign gpio_rise = gpio_s & ~gpio_d;
    assign gpio_any  = gpio_s ^ gpio_d;

    // Input synchronisers plus one delay stage for edge detection.
    always_ff @(posedge clk50m or negedge reset_rtl_0) begin
        if (!reset_rtl_0) begin
            calib_m <= 1'b0;
            calib_s <= 1'b0;
            gpio_m  <= 1'b0;
            gpio_s  <= 1'b0;
            gpio_d  <= 1'b0;
        end else begin
            calib_m <= init_calib_complete_0;
            calib_s <= calib_m;
            gpio_m  <= gpio_io_o_0;
            gpio_s  <= gpio_m;
            gpio_d  <= gpio_s;
        end
    end

    // Heartbeat and fast-blink dividers; both free-run in every state.
    always_ff @(posedge clk50m or negedge reset_rtl_0) begin
        if (!reset_rtl_0) begin
            hb_cnt   <= '0;
            hb       <= 1'b0;
            fast_cnt <= '0;
            fast     <= 1'b0;
        end else begin
            if (hb_cnt == HB_LAST) begin
                hb_cnt <= '0;
                hb     <= ~hb;
            end else begin
                hb_cnt <= hb_cnt + HB_W'(1);
            end
            if (fast_cnt == FAST_LAST) begin
                fast_cnt <= '0;
                fast     <= ~fast;
            end else begin
                fast_cnt <= fast_cnt + FAST_W'(1);
            end
        end
    end

    // Watchdog timer, GPIO edge counter and activity stretcher.
    always_ff @(posedge clk50m or negedge reset_rtl_0) begin
        if (!reset_rtl_0) begin
            timer    <= '0;
            edge_cnt <= '0;
            act      <= '0;
        end else begin
            if (state == WAIT_CALIB) begin
                timer <= timer + TIMER_W'(1);
            end
            if (gpio_rise) begin
                edge_cnt <= edge_cnt + 3'd1;
            end
            if (gpio_any) begin
                act <= ACT_LOAD;
            end else if (act != '0) begin
                act <= act - ACT_W'(1);
            end
        end
    end

    // Calibration FSM: state register.
    always_ff @(posedge clk50m or negedge reset_rtl_0) begin
        if (!reset_rtl_0) begin
            state <= WAIT_CALIB;
        end else begin
            state <= state_next;
        end
    end

    // Calibration FSM: next state. Calibration seen wins over the timeout.
    always_comb begin
        state_next = state;
        case (state)
            WAIT_CALIB: begin
                if (calib_s) begin
                    state_next = RUN;
                end else if (timer == TIMER_LAST) begin
                    state_next = TIMEOUT;
                end
            end
            TIMEOUT: begin
                if (calib_s) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!calib_s) begin
                    state_next = LOST;
                end
            end
            LOST: begin
                state_next = LOST;
            end
        endcase
    end

    // Calibration FSM: LED outputs, registered below.
    always_comb begin
        led_next      = '0;
        led_next[1]   = gpio_s;
        led_next[2]   = (act != '0);
        led_next[5:3] = edge_cnt;
        led_next[7]   = hb;
        case (state)
            WAIT_CALIB: led_next[0] = hb;
            RUN:        led_next[0] = 1'b1;
            TIMEOUT:    led_next[6] = fast;
            LOST:       led_next[6] = 1'b1;
        endcase
    end

    always_ff @(posedge clk50m or negedge reset_rtl_0) begin
        if (!reset_rtl_0) begin
            led <= '0;
        end else begin
            led <= led_next;
        end
    end

endmodule
